// File: rtl/fetch_stage.sv
// fetch_stage: PC, in-order instruction memory requests and a small instruction FIFO feeding decode
// Build option FETCH_MISALIGN_TRAP_EN: adds out_fault and a HALT state entered on misaligned redirect targets.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        out_fault
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {HOLD, FETCH, HALT} state_t;
`else
    typedef enum logic {HOLD, FETCH} state_t;
`endif

    state_t        state, state_nxt;
    logic [31:0]   pc, rsp_pc, tgt, wr_instr;
    logic [CW-1:0] outstanding, drop_cnt, count;
    logic [CW:0]   credit;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   instr_buf [FIFO_DEPTH];
    logic [31:0]   pc_buf [FIFO_DEPTH];
    logic          accept, drop, rsp_push, push, pop;

    // Outstanding requests reserve FIFO slots, so responses never need back-pressure
    assign credit         = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = rst_n && state == FETCH && !redirect_valid && credit < (CW+1)'(FIFO_DEPTH);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign drop           = drop_cnt != '0;
    assign rsp_push       = imem_rsp_valid && !drop && !redirect_valid;
    assign out_valid      = rst_n && count != '0;
    assign pop            = out_valid && out_ready && !redirect_valid;
    assign out_instr      = instr_buf[rd_ptr];
    assign out_pc         = pc_buf[rd_ptr];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_pend, misalign;
    logic fault_buf [FIFO_DEPTH];
    assign misalign  = redirect_pc[1:0] != 2'b00;
    assign tgt       = redirect_pc;
    assign push      = rsp_push || (fault_pend && !redirect_valid);
    assign wr_instr  = fault_pend ? 32'h0000_0013 : imem_rsp_data;
    assign out_fault = out_valid && fault_buf[rd_ptr];
    always_comb state_nxt = redirect_valid ? (misalign ? HALT : FETCH) : (state == HOLD ? FETCH : state);
    // The fault entry lands one cycle after the flush so out_valid still drops for a cycle
    always_ff @(posedge clk) begin
        fault_pend <= rst_n && redirect_valid && misalign;
        if (push) fault_buf[wr_ptr] <= fault_pend;
    end
`else
    assign tgt      = redirect_pc & 32'hFFFF_FFFC;
    assign push     = rsp_push;
    assign wr_instr = imem_rsp_data;
    always_comb state_nxt = (redirect_valid || state == HOLD) ? FETCH : state;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HOLD;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc       <= tgt;
                rsp_pc   <= tgt;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (accept) pc <= pc + 32'd4;
                if (imem_rsp_valid && drop) drop_cnt <= drop_cnt - CW'(1);
                // rsp_pc is the PC of the oldest live request; requests since a redirect are contiguous
                if (rsp_push) rsp_pc <= rsp_pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_buf[wr_ptr] <= wr_instr;
            pc_buf[wr_ptr]    <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench driving fetch_stage with a latency-configurable memory model
// and a cycle model of the fetch pipeline; expected entries queue on responses, compare on output.
`timescale 1ns/1ps
module tb_fetch_stage;
    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int M_HOLD = 0, M_FETCH = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        out_fault;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .out_fault(out_fault)
`endif
    );

    typedef struct {logic [31:0] instr; logic [31:0] pc; logic fault;} entry_t;
    typedef struct {logic [31:0] addr; logic [31:0] epc; int due;} mreq_t;

    entry_t      exp_q[$];
    mreq_t       mem_q[$];
    int          n_checks = 0, n_err = 0, cyc = 0, lat = 1, n_acc = 0;
    int          m_state = M_HOLD, m_inflight = 0, m_drop = 0;
    logic [31:0] m_pc = RPC;
    bit          fault_pend = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h00A5_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, compare at negedge, advance the model, cross posedge
    task automatic step();
        logic  rsp, exp_req, acc, pop;
        mreq_t r;
        rsp = mem_q.size() != 0 && mem_q[0].due <= cyc;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : 32'h0;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_req_valid", imem_req_valid, 0);
            check("rst_out_valid", out_valid, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
            check("rst_out_fault", out_fault, 0);
`endif
            m_state = M_HOLD; m_pc = RPC; m_inflight = 0; m_drop = 0; fault_pend = 0;
            exp_q.delete();
            mem_q.delete();
        end else begin
            exp_req = m_state == M_FETCH && m_inflight + exp_q.size() < D && !redirect_valid;
            check("req_valid", imem_req_valid, exp_req);
            if (exp_req) check("req_addr", imem_req_addr, m_pc);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("out_instr", out_instr, exp_q[0].instr);
                check("out_pc", out_pc, exp_q[0].pc);
`ifdef FETCH_MISALIGN_TRAP_EN
                check("out_fault", out_fault, exp_q[0].fault);
`endif
            end
            acc = exp_req && imem_req_ready;
            pop = exp_q.size() != 0 && out_ready && !redirect_valid;
            if (rsp) r = mem_q.pop_front();
            if (acc) begin
                mem_q.push_back('{imem_req_addr, m_pc, cyc + lat});
                n_acc++;
            end
            if (redirect_valid) begin
                m_drop = m_inflight - int'(rsp);
                m_inflight = m_drop;
                exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc = redirect_pc;
                fault_pend = redirect_pc[1:0] != 2'b00;
                m_state = fault_pend ? M_HALT : M_FETCH;
`else
                m_pc = {redirect_pc[31:2], 2'b00};
                m_state = M_FETCH;
`endif
            end else begin
                if (pop) void'(exp_q.pop_front());
                if (fault_pend) begin
                    exp_q.push_back('{32'h0000_0013, m_pc, 1'b1});
                    fault_pend = 0;
                end
                if (rsp) begin
                    if (m_drop > 0) m_drop--;
                    else exp_q.push_back('{mem_word(r.epc), r.epc, 1'b0});
                    m_inflight--;
                end
                if (acc) begin
                    m_pc += 32'd4;
                    m_inflight++;
                end
                if (m_state == M_HOLD) m_state = M_FETCH;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 30 && !out_valid; k++) step();
        check(tag, out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        rst_n = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        repeat (3) step();

        // 1: first output three cycles after reset release
        rst_n = 1'b1;
        repeat (3) step();
        check("t1_first_valid", out_valid, 1);
        check("t1_first_pc", out_pc, RPC);
        check("t1_first_instr", out_instr, mem_word(RPC));
        repeat (10) step();

        // 2: stalled decoder allows exactly FIFO_DEPTH requests
        out_ready = 1'b0;
        redirect_to(32'h0000_0040);
        a0 = n_acc;
        repeat (12) step();
        check("t2_credit", n_acc - a0, D);
        check("t2_req_idle", imem_req_valid, 0);
        check("t2_head_pc", out_pc, 32'h0000_0040);
        out_ready = 1'b1;
        repeat (10) step();

        // 3: redirect with two stale responses in flight
        lat = 3;
        for (int k = 0; k < 20 && m_inflight != 2; k++) step();
        redirect_to(32'h0000_0100);
        wait_valid("t3_valid");
        check("t3_pc", out_pc, 32'h0000_0100);
        check("t3_instr", out_instr, mem_word(32'h0000_0100));
        repeat (10) step();

        // 4: fill, then stream with simultaneous push/pop and a flaky request port
        lat = 1;
        out_ready = 1'b0;
        repeat (8) step();
        check("t4_full_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (30) begin
            imem_req_ready = $urandom_range(0, 3) != 0;
            step();
        end
        imem_req_ready = 1'b1;

        // 5: reset mid-stream with requests outstanding
        lat = 3;
        for (int k = 0; k < 20 && m_inflight == 0; k++) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("t5_restart_valid", imem_req_valid, 1);
        check("t5_restart_addr", imem_req_addr, RPC);
        repeat (12) step();

`ifdef FETCH_MISALIGN_TRAP_EN
        // 6: misaligned redirect yields one fault entry and halts fetch
        out_ready = 1'b0;
        redirect_to(32'h0000_0102);
        check("t6_gap", out_valid, 0);
        step();
        check("t6_valid", out_valid, 1);
        check("t6_fault", out_fault, 1);
        check("t6_pc", out_pc, 32'h0000_0102);
        check("t6_instr", out_instr, 32'h0000_0013);
        repeat (6) step();
        check("t6_noreq", imem_req_valid, 0);
        out_ready = 1'b1;
        redirect_to(32'h0000_0200);
        wait_valid("t6_resume_valid");
        check("t6_resume_pc", out_pc, 32'h0000_0200);
        check("t6_resume_fault", out_fault, 0);
        repeat (6) step();
`endif

        // Random traffic across memory latencies
        for (int p = 0; p < 4; p++) begin
            lat = 1 + p % 3;
            repeat (100) begin
                imem_req_ready = $urandom_range(0, 3) != 0;
                out_ready      = $urandom_range(0, 2) != 0;
                redirect_valid = $urandom_range(0, 19) == 0;
                redirect_pc    = $urandom;
                step();
            end
        end
        redirect_valid = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
